mcore_looper_arbiter: RTL and testbench

MCORE_LOOPER_ARBITER -- requirements
Module: bp_mcore_looper_arbiter

---
 rtl/mcore_looper_arbiter.sv | 143 ++++++++++++++
 tb/tb_mcore_looper_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcore_looper_arbiter.sv
// mcore_looper_arbiter
// Round-robin arbiter that funnels several core command channels into one
// looper device and steers the in-order responses back to their originators.
// A small tag FIFO records which core issued each accepted command. A response
// that arrives while no tag is outstanding is consumed, dropped, and latched
// in a sticky error flag.

module mcore_looper_arbiter #(
    parameter int unsigned num_cores_p       = 2,
    parameter int unsigned msg_width_p       = 128,
    parameter int unsigned max_outstanding_p = 2
) (
    input  logic                               clk_i,
    input  logic                               reset_i,

    input  logic [num_cores_p*msg_width_p-1:0] core_cmd_i,
    input  logic [num_cores_p-1:0]             core_cmd_v_i,
    output logic [num_cores_p-1:0]             core_cmd_ready_o,

    output logic [msg_width_p-1:0]             mem_cmd_o,
    output logic                               mem_cmd_v_o,
    input  logic                               mem_cmd_ready_i,

    input  logic [msg_width_p-1:0]             mem_resp_i,
    input  logic                               mem_resp_v_i,
    output logic                               mem_resp_yumi_o,

    output logic [msg_width_p-1:0]             core_resp_o,
    output logic [num_cores_p-1:0]             core_resp_v_o,
    input  logic [num_cores_p-1:0]             core_resp_yumi_i,

    output logic                               error_o
);

    localparam int unsigned core_idx_w = (num_cores_p > 1) ? $clog2(num_cores_p) : 1;
    localparam int unsigned ptr_w      = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int unsigned cnt_w      = $clog2(max_outstanding_p + 1);

    localparam logic [core_idx_w-1:0] last_core = core_idx_w'(num_cores_p - 1);
    localparam logic [ptr_w-1:0]      last_slot = ptr_w'(max_outstanding_p - 1);
    localparam logic [cnt_w-1:0]      full_cnt  = cnt_w'(max_outstanding_p);

    // Architectural state
    logic [core_idx_w-1:0] rr_r;
    logic [core_idx_w-1:0] tag_mem_r [max_outstanding_p];
    logic [ptr_w-1:0]      wr_ptr_r;
    logic [ptr_w-1:0]      rd_ptr_r;
    logic [cnt_w-1:0]      count_r;
    logic                  error_r;

    // Combinational helpers
    logic                  tag_full;
    logic                  tag_empty;
    logic [core_idx_w-1:0] grant_idx;
    logic [core_idx_w-1:0] cand_idx;
    logic                  grant_hit;
    logic                  cmd_hs;
    logic [core_idx_w-1:0] rr_next;
    logic [core_idx_w-1:0] head_tag;
    logic                  resp_v;
    logic                  resp_pop;
    logic                  resp_spurious;

    assign tag_empty = (count_r == '0);
    assign tag_full  = (count_r == full_cnt);

    // Round-robin search: first valid core starting at rr_r, wrapping modulo num_cores_p
    always_comb begin
        grant_idx = rr_r;
        cand_idx  = '0;
        grant_hit = 1'b0;
        for (int unsigned i = 0; i < num_cores_p; i++) begin
            cand_idx = core_idx_w'((32'(rr_r) + i) % num_cores_p);
            if (!grant_hit && core_cmd_v_i[cand_idx]) begin
                grant_hit = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // Command path: zero-latency mux of the granted core; a full tag FIFO blocks
    // issue regardless of any pop in the same cycle. reset_i gates the valid so
    // nothing escapes while reset is held.
    assign mem_cmd_v_o      = reset_i & (|core_cmd_v_i) & ~tag_full;
    assign mem_cmd_o        = core_cmd_i[grant_idx*msg_width_p +: msg_width_p];
    assign cmd_hs           = mem_cmd_v_o & mem_cmd_ready_i;
    assign core_cmd_ready_o = cmd_hs ? (num_cores_p'(1) << grant_idx) : '0;
    assign rr_next          = (grant_idx == last_core) ? '0 : grant_idx + core_idx_w'(1);

    // Response path: route to the head tag; a response with no tag is swallowed
    assign head_tag        = tag_mem_r[rd_ptr_r];
    assign resp_v          = mem_resp_v_i & ~tag_empty;
    assign core_resp_o     = mem_resp_i;
    assign core_resp_v_o   = resp_v ? (num_cores_p'(1) << head_tag) : '0;
    assign resp_pop        = resp_v & core_resp_yumi_i[head_tag];
    assign resp_spurious   = reset_i & mem_resp_v_i & tag_empty;
    assign mem_resp_yumi_o = resp_pop | resp_spurious;
    assign error_o         = error_r;

    // Round-robin pointer advances past the granted core only on a handshake
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rr_r <= '0;
        end else if (cmd_hs) begin
            rr_r <= rr_next;
        end
    end

    // Tag FIFO: write on command handshake, read on response handshake
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int unsigned i = 0; i < max_outstanding_p; i++) begin
                tag_mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (cmd_hs) begin
                tag_mem_r[wr_ptr_r] <= grant_idx;
                wr_ptr_r            <= (wr_ptr_r == last_slot) ? '0 : wr_ptr_r + ptr_w'(1);
            end
            if (resp_pop) begin
                rd_ptr_r <= (rd_ptr_r == last_slot) ? '0 : rd_ptr_r + ptr_w'(1);
            end
            if (cmd_hs && !resp_pop) begin
                count_r <= count_r + cnt_w'(1);
            end else if (resp_pop && !cmd_hs) begin
                count_r <= count_r - cnt_w'(1);
            end
        end
    end

    // Sticky error on any response that found no outstanding tag
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            error_r <= 1'b0;
        end else if (resp_spurious) begin
            error_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mcore_looper_arbiter.sv
// Directed bench for mcore_looper_arbiter: 2 cores, 32-bit messages, 2 tags.
// Accepted commands push their expected owner into a scoreboard queue; each
// response cycle peeks/pops that queue to predict routing and consume.

module tb_mcore_looper_arbiter;

    localparam int unsigned NC = 2;
    localparam int unsigned W  = 32;
    localparam int unsigned D  = 2;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [W-1:0]      cmd0;
    logic [W-1:0]      cmd1;
    logic [NC*W-1:0]   core_cmd_i;
    logic [NC-1:0]     core_cmd_v_i;
    logic [NC-1:0]     core_cmd_ready_o;
    logic [W-1:0]      mem_cmd_o;
    logic              mem_cmd_v_o;
    logic              mem_cmd_ready_i;
    logic [W-1:0]      mem_resp_i;
    logic              mem_resp_v_i;
    logic              mem_resp_yumi_o;
    logic [W-1:0]      core_resp_o;
    logic [NC-1:0]     core_resp_v_o;
    logic [NC-1:0]     core_resp_yumi_i;
    logic              error_o;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned owner_q[$];

    always #5 clk = ~clk;

    assign core_cmd_i = {cmd1, cmd0};

    mcore_looper_arbiter #(
        .num_cores_p      (NC),
        .msg_width_p      (W),
        .max_outstanding_p(D)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .core_cmd_i      (core_cmd_i),
        .core_cmd_v_i    (core_cmd_v_i),
        .core_cmd_ready_o(core_cmd_ready_o),
        .mem_cmd_o       (mem_cmd_o),
        .mem_cmd_v_o     (mem_cmd_v_o),
        .mem_cmd_ready_i (mem_cmd_ready_i),
        .mem_resp_i      (mem_resp_i),
        .mem_resp_v_i    (mem_resp_v_i),
        .mem_resp_yumi_o (mem_resp_yumi_o),
        .core_resp_o     (core_resp_o),
        .core_resp_v_o   (core_resp_v_o),
        .core_resp_yumi_i(core_resp_yumi_i),
        .error_o         (error_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] v, input logic rdy);
        core_cmd_v_i    = v;
        mem_cmd_ready_i = rdy;
        cmd0            = $urandom;
        cmd1            = $urandom;
    endtask

    task automatic drive_resp(input logic v, input logic [1:0] yumi);
        mem_resp_v_i     = v;
        mem_resp_i       = $urandom;
        core_resp_yumi_i = yumi;
    endtask

    // Predict response routing/consume from the scoreboard head; pop on handshake
    task automatic check_resp(input string tag);
        logic [1:0] exp_v;
        logic       exp_y;
        exp_v = 2'b00;
        exp_y = 1'b0;
        if (mem_resp_v_i) begin
            if (owner_q.size() == 0) begin
                exp_y = 1'b1;
            end else begin
                exp_v = 2'b01 << owner_q[0];
                exp_y = core_resp_yumi_i[owner_q[0]];
            end
        end
        chk({tag, ".resp_v"}, 32'(core_resp_v_o), 32'(exp_v));
        chk({tag, ".resp_yumi"}, 32'(mem_resp_yumi_o), 32'(exp_y));
        if (mem_resp_v_i) chk({tag, ".resp_data"}, core_resp_o, mem_resp_i);
        if (mem_resp_v_i && owner_q.size() != 0 && exp_y) void'(owner_q.pop_front());
    endtask

    // Check command-side outputs against the directed expectation; push owner on accept
    task automatic check_cmd(input string tag, input logic exp_v, input logic [1:0] exp_rdy,
                             input int unsigned exp_g);
        chk({tag, ".cmd_v"}, 32'(mem_cmd_v_o), 32'(exp_v));
        chk({tag, ".cmd_ready"}, 32'(core_cmd_ready_o), 32'(exp_rdy));
        if (exp_v) chk({tag, ".cmd_data"}, mem_cmd_o, (exp_g == 0) ? cmd0 : cmd1);
        if (exp_rdy != 2'b00) owner_q.push_back(exp_g);
    endtask

    task automatic step(input string tag, input logic [1:0] cv, input logic rdy,
                        input logic rv, input logic [1:0] yumi,
                        input logic exp_v, input logic [1:0] exp_rdy, input int unsigned exp_g);
        drive_cmd(cv, rdy);
        drive_resp(rv, yumi);
        #1;
        check_resp(tag);
        check_cmd(tag, exp_v, exp_rdy, exp_g);
        advance();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with busy inputs: control outputs must stay low
        reset_i = 1'b0;
        drive_cmd(2'b11, 1'b1);
        drive_resp(1'b1, 2'b11);
        #2;
        chk("rst.cmd_ready", 32'(core_cmd_ready_o), 32'd0);
        chk("rst.cmd_v", 32'(mem_cmd_v_o), 32'd0);
        chk("rst.resp_yumi", 32'(mem_resp_yumi_o), 32'd0);
        chk("rst.resp_v", 32'(core_resp_v_o), 32'd0);
        chk("rst.error", 32'(error_o), 32'd0);
        advance();
        advance();
        drive_cmd(2'b00, 1'b0);
        drive_resp(1'b0, 2'b00);
        reset_i = 1'b1;
        advance();

        // Single core 1 request and its response
        step("t1.cmd",  2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10, 1);
        step("t1.resp", 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 0);

        // Contention: rr back at 0, grants alternate while responses drain
        step("t2.c0", 2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 0);
        step("t2.c1", 2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 1);
        step("t2.c2", 2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b01, 0);
        step("t2.c3", 2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10, 1);
        step("t2.drain", 2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 0);

        // Full FIFO: third command blocked even with a same-cycle pop
        step("t3.a", 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 0);
        step("t3.b", 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 0);
        step("t3.full_pop", 2'b01, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 0);
        step("t3.retry", 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 0);
        step("t3.drain0", 2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 0);
        step("t3.drain1", 2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 0);

        // Backpressure with rr=1: core 1 keeps priority through the stall
        step("t4.stall0", 2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1);
        step("t4.stall1", 2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1);
        step("t4.stall2", 2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1);
        step("t4.go1", 2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10, 1);
        step("t4.go0", 2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 0);

        // Core stall: head core 0 withholds yumi while core 1 asserts its own
        step("t5.pop1", 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 0);
        step("t5.hold0", 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 0);
        step("t5.hold1", 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 0);
        step("t5.pop0", 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 0);

        // Spurious response on empty FIFO: dropped, sticky error, cleared by reset
        drive_cmd(2'b00, 1'b0);
        drive_resp(1'b1, 2'b11);
        #1;
        check_resp("t6.spur");
        chk("t6.err_pre", 32'(error_o), 32'd0);
        advance();
        drive_resp(1'b0, 2'b00);
        #1;
        chk("t6.err_set", 32'(error_o), 32'd1);
        advance();
        advance();
        chk("t6.err_held", 32'(error_o), 32'd1);
        drive_cmd(2'b11, 1'b1);
        drive_resp(1'b1, 2'b11);
        reset_i = 1'b0;
        #1;
        owner_q.delete();
        chk("t6.err_clr", 32'(error_o), 32'd0);
        chk("t6.rst_cmd_v", 32'(mem_cmd_v_o), 32'd0);
        chk("t6.rst_ready", 32'(core_cmd_ready_o), 32'd0);
        chk("t6.rst_yumi", 32'(mem_resp_yumi_o), 32'd0);
        advance();
        drive_cmd(2'b00, 1'b0);
        drive_resp(1'b0, 2'b00);
        reset_i = 1'b1;
        advance();

        // Reset mid-transaction discards the outstanding tag
        step("t7.cmd", 2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10, 1);
        drive_cmd(2'b00, 1'b0);
        reset_i = 1'b0;
        #1;
        owner_q.delete();
        advance();
        reset_i = 1'b1;
        advance();
        step("t7.spur_cmd", 2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 2'b01, 0);
        step("t7.resp0", 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 0);
        drive_resp(1'b0, 2'b00);
        #1;
        chk("t7.err", 32'(error_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
